// File: rtl/tank_pkg.sv
// Shared definitions for the tank game's bullet and map engine.
// Holds the grid geometry, tile codes, facing directions, the engine
// FSM states, the per-step action codes from the bullet resolver, the
// bullet record, the power-on map layout, and the bullet update helper.
package tank_pkg;

  localparam int GRID_W   = 20;
  localparam int GRID_H   = 15;
  localparam int MAP_SIZE = GRID_W * GRID_H;
  localparam int BUL_OFF  = 31;

  // An inactive bullet parks here. The value is outside both grid ranges,
  // so it never matches a visible tile.
  localparam logic [4:0] BUL_OFF_5 = 5'd31;

  localparam logic [2:0] TILE_EMPTY = 3'd0;
  localparam logic [2:0] TILE_STEEL = 3'd1;
  localparam logic [2:0] TILE_BRICK = 3'd2;
  localparam logic [2:0] TILE_BASE1 = 3'd3;
  localparam logic [2:0] TILE_BASE2 = 3'd4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_B1_CALC,
    ST_B1_APPLY,
    ST_B2_CALC,
    ST_B2_APPLY
  } eng_state_t;

  typedef enum logic [2:0] {
    ACT_MOVE,
    ACT_KILL,
    ACT_CLEAR,
    ACT_TANK_HIT,
    ACT_BASE_HIT
  } action_t;

  typedef struct packed {
    logic       active;
    logic [4:0] x;
    logic [4:0] y;
    dir_t       dir;
  } bullet_t;

  // Power-on layout: two steel walls across the middle row, two brick
  // rows, one lone brick at (5,2), and each base boxed in by bricks
  // (base of tank two at the top, base of tank one at the bottom).
  function automatic logic [2:0] init_tile(input int x, input int y);
    logic [2:0] t;
    t = TILE_EMPTY;
    if (y == 7 && ((x >= 3 && x <= 6) || (x >= 13 && x <= 16))) t = TILE_STEEL;
    if ((y == 4 || y == 10) && x >= 8 && x <= 11) t = TILE_BRICK;
    if (x == 5 && y == 2) t = TILE_BRICK;
    if (x >= 9 && x <= 11 && (y <= 1 || y >= 13)) t = TILE_BRICK;
    if (x == 10 && y == 0) t = TILE_BASE2;
    if (x == 10 && y == 14) t = TILE_BASE1;
    return t;
  endfunction

  function automatic logic [3*MAP_SIZE-1:0] build_init_map();
    logic [3*MAP_SIZE-1:0] m;
    m = '0;
    for (int y = 0; y < GRID_H; y++) begin
      for (int x = 0; x < GRID_W; x++) begin
        m[3*(y*GRID_W+x) +: 3] = init_tile(x, y);
      end
    end
    return m;
  endfunction

  // Tile i occupies bits [3*i +: 3].
  localparam logic [3*MAP_SIZE-1:0] INIT_MAP = build_init_map();

  // Only a MOVE keeps the bullet alive; every other outcome retires it.
  function automatic bullet_t apply_action(input bullet_t cur, input action_t act,
                                           input logic [4:0] x, input logic [4:0] y,
                                           input dir_t d);
    bullet_t nxt;
    nxt = cur;
    if (act == ACT_MOVE) begin
      nxt.active = 1'b1;
      nxt.x      = x;
      nxt.y      = y;
      nxt.dir    = d;
    end else begin
      nxt.active = 1'b0;
      nxt.x      = BUL_OFF_5;
      nxt.y      = BUL_OFF_5;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bullet_resolve.sv
// Combinational single-step resolver for one bullet.
// Ports:
//   src_x, src_y     : tile the bullet steps from
//   dir              : direction of the step
//   opp_x, opp_y     : tile of the opposing tank
//   tile_code        : map word at the target tile (ignored when out of bounds)
//   tgt_x, tgt_y     : target tile (signed, may be off-grid)
//   in_bounds        : target lies inside the grid
//   action           : MOVE, KILL, CLEAR (brick), TANK_HIT or BASE_HIT
module bullet_resolve
  import tank_pkg::*;
(
  input  int         src_x,
  input  int         src_y,
  input  dir_t       dir,
  input  int         opp_x,
  input  int         opp_y,
  input  logic [2:0] tile_code,
  output int         tgt_x,
  output int         tgt_y,
  output logic       in_bounds,
  output action_t    action
);

  always_comb begin
    tgt_x = src_x;
    tgt_y = src_y;
    case (dir)
      DIR_UP:    tgt_y = src_y - 1;
      DIR_RIGHT: tgt_x = src_x + 1;
      DIR_DOWN:  tgt_y = src_y + 1;
      DIR_LEFT:  tgt_x = src_x - 1;
      default:   tgt_x = src_x;
    endcase
  end

  always_comb begin
    in_bounds = (tgt_x >= 0) && (tgt_x < GRID_W) && (tgt_y >= 0) && (tgt_y < GRID_H);
  end

  // Leaving the grid beats everything; the opposing tank beats whatever
  // tile it stands on. Unknown tile codes are treated as solid.
  always_comb begin
    action = ACT_KILL;
    if (!in_bounds) begin
      action = ACT_KILL;
    end else if (tgt_x == opp_x && tgt_y == opp_y) begin
      action = ACT_TANK_HIT;
    end else begin
      case (tile_code)
        TILE_EMPTY: action = ACT_MOVE;
        TILE_STEEL: action = ACT_KILL;
        TILE_BRICK: action = ACT_CLEAR;
        TILE_BASE1: action = ACT_BASE_HIT;
        TILE_BASE2: action = ACT_BASE_HIT;
        default:    action = ACT_KILL;
      endcase
    end
  end

endmodule

// File: rtl/bullet_map_engine.sv
// Owns the 20x15 tile map and both bullets. Once per frame_tick it steps
// bullet one and then bullet two by one tile, resolving hits against the
// map and the opposing tank, and clears struck brick/base tiles.
// Ports:
//   Clk, Reset_n                 : clock, async active-low reset
//   frame_tick                   : one-cycle frame pulse
//   fire1/fire2, dir1/dir2       : fire request and facing per tank
//   TankOneX/Y, TankTwoX/Y       : tank tile positions
//   BulOneX/Y, BulTwoX/Y         : bullet tiles, 31 when inactive
//   map                          : tile codes, index y*20+x
//   hit1/hit2, base_hit          : one-cycle strike pulses
//   busy, overrun                : frame in progress / tick dropped
module bullet_map_engine
  import tank_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       fire1,
  input  logic       fire2,
  input  int         TankOneX,
  input  int         TankOneY,
  input  int         TankTwoX,
  input  int         TankTwoY,
  input  logic [1:0] dir1,
  input  logic [1:0] dir2,
  output int         BulOneX,
  output int         BulOneY,
  output int         BulTwoX,
  output int         BulTwoY,
  output int         map [MAP_SIZE],
  output logic       hit1,
  output logic       hit2,
  output logic [1:0] base_hit,
  output logic       busy,
  output logic       overrun
);

  eng_state_t state_q, state_d;
  logic [2:0] map_q [MAP_SIZE];
  logic [2:0] map_d [MAP_SIZE];
  bullet_t    bul1_q, bul1_d, bul2_q, bul2_d;

  logic fire1_snap_q, fire1_snap_d, fire2_snap_q, fire2_snap_d;
  int   t1x_snap_q, t1x_snap_d, t1y_snap_q, t1y_snap_d;
  int   t2x_snap_q, t2x_snap_d, t2y_snap_q, t2y_snap_d;
  dir_t dir1_snap_q, dir1_snap_d, dir2_snap_q, dir2_snap_d;

  logic       calc_valid_q, calc_valid_d;
  action_t    calc_act_q, calc_act_d;
  logic [4:0] calc_x_q, calc_x_d, calc_y_q, calc_y_d;
  logic [8:0] calc_idx_q, calc_idx_d;
  dir_t       calc_dir_q, calc_dir_d;
  logic [1:0] calc_base_q, calc_base_d;

  logic       hit1_q, hit1_d, hit2_q, hit2_d, overrun_q, overrun_d;
  logic [1:0] base_hit_q, base_hit_d;

  bullet_t    sel_bul;
  logic       sel_fire;
  logic       sel_valid;
  int         sel_src_x, sel_src_y, sel_opp_x, sel_opp_y;
  dir_t       sel_dir;
  int         res_tgt_x, res_tgt_y;
  logic       res_in_bounds;
  action_t    res_action;
  logic [8:0] res_idx;
  logic [2:0] res_tile;

  // The single resolver serves bullet two during B2_CALC and bullet one
  // otherwise. An inactive bullet that is firing starts from its own tank
  // with the snapshot direction, so a spawn resolves exactly like a step.
  always_comb begin
    sel_bul   = (state_q == ST_B2_CALC) ? bul2_q       : bul1_q;
    sel_fire  = (state_q == ST_B2_CALC) ? fire2_snap_q : fire1_snap_q;
    sel_opp_x = (state_q == ST_B2_CALC) ? t1x_snap_q   : t2x_snap_q;
    sel_opp_y = (state_q == ST_B2_CALC) ? t1y_snap_q   : t2y_snap_q;
    sel_valid = sel_bul.active | sel_fire;
    if (sel_bul.active) begin
      sel_src_x = int'(sel_bul.x);
      sel_src_y = int'(sel_bul.y);
      sel_dir   = sel_bul.dir;
    end else begin
      sel_src_x = (state_q == ST_B2_CALC) ? t2x_snap_q  : t1x_snap_q;
      sel_src_y = (state_q == ST_B2_CALC) ? t2y_snap_q  : t1y_snap_q;
      sel_dir   = (state_q == ST_B2_CALC) ? dir2_snap_q : dir1_snap_q;
    end
  end

  bullet_resolve u_resolve (
    .src_x     (sel_src_x),
    .src_y     (sel_src_y),
    .dir       (sel_dir),
    .opp_x     (sel_opp_x),
    .opp_y     (sel_opp_y),
    .tile_code (res_tile),
    .tgt_x     (res_tgt_x),
    .tgt_y     (res_tgt_y),
    .in_bounds (res_in_bounds),
    .action    (res_action)
  );

  // The index is only formed for in-bounds targets so a negative or
  // oversized coordinate never addresses the map.
  always_comb begin
    res_idx  = res_in_bounds ? 9'(res_tgt_y * GRID_W + res_tgt_x) : 9'd0;
    res_tile = map_q[res_idx];
  end

  // Next-state logic for the whole engine. Bullet two's CALC reads map_q
  // after bullet one's APPLY has written it, so a brick cleared by bullet
  // one is already empty when bullet two looks at it.
  always_comb begin
    state_d      = state_q;
    map_d        = map_q;
    bul1_d       = bul1_q;
    bul2_d       = bul2_q;
    fire1_snap_d = fire1_snap_q;
    fire2_snap_d = fire2_snap_q;
    t1x_snap_d   = t1x_snap_q;
    t1y_snap_d   = t1y_snap_q;
    t2x_snap_d   = t2x_snap_q;
    t2y_snap_d   = t2y_snap_q;
    dir1_snap_d  = dir1_snap_q;
    dir2_snap_d  = dir2_snap_q;
    calc_valid_d = calc_valid_q;
    calc_act_d   = calc_act_q;
    calc_x_d     = calc_x_q;
    calc_y_d     = calc_y_q;
    calc_idx_d   = calc_idx_q;
    calc_dir_d   = calc_dir_q;
    calc_base_d  = calc_base_q;
    hit1_d       = 1'b0;
    hit2_d       = 1'b0;
    base_hit_d   = 2'b00;
    overrun_d    = frame_tick && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d      = ST_B1_CALC;
          fire1_snap_d = fire1;
          fire2_snap_d = fire2;
          t1x_snap_d   = TankOneX;
          t1y_snap_d   = TankOneY;
          t2x_snap_d   = TankTwoX;
          t2y_snap_d   = TankTwoY;
          dir1_snap_d  = dir_t'(dir1);
          dir2_snap_d  = dir_t'(dir2);
        end
      end
      ST_B1_CALC, ST_B2_CALC: begin
        state_d      = (state_q == ST_B1_CALC) ? ST_B1_APPLY : ST_B2_APPLY;
        calc_valid_d = sel_valid;
        calc_act_d   = res_action;
        calc_x_d     = 5'(res_tgt_x);
        calc_y_d     = 5'(res_tgt_y);
        calc_idx_d   = res_idx;
        calc_dir_d   = sel_dir;
        calc_base_d  = (res_tile == TILE_BASE1) ? 2'b01 : 2'b10;
      end
      ST_B1_APPLY: begin
        state_d = ST_B2_CALC;
        if (calc_valid_q) begin
          bul1_d = apply_action(bul1_q, calc_act_q, calc_x_q, calc_y_q, calc_dir_q);
          hit2_d = (calc_act_q == ACT_TANK_HIT);
        end
      end
      ST_B2_APPLY: begin
        state_d = ST_IDLE;
        if (calc_valid_q) begin
          bul2_d = apply_action(bul2_q, calc_act_q, calc_x_q, calc_y_q, calc_dir_q);
          hit1_d = (calc_act_q == ACT_TANK_HIT);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Only the two APPLY states ever write the map, one tile at most.
    if ((state_q == ST_B1_APPLY || state_q == ST_B2_APPLY) && calc_valid_q) begin
      if (calc_act_q == ACT_CLEAR || calc_act_q == ACT_BASE_HIT) begin
        map_d[calc_idx_q] = TILE_EMPTY;
      end
      if (calc_act_q == ACT_BASE_HIT) begin
        base_hit_d = calc_base_q;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < MAP_SIZE; i++) begin
        map_q[i] <= INIT_MAP[3*i +: 3];
      end
      bul1_q       <= '{active: 1'b0, x: BUL_OFF_5, y: BUL_OFF_5, dir: DIR_UP};
      bul2_q       <= '{active: 1'b0, x: BUL_OFF_5, y: BUL_OFF_5, dir: DIR_UP};
      fire1_snap_q <= 1'b0;
      fire2_snap_q <= 1'b0;
      t1x_snap_q   <= 0;
      t1y_snap_q   <= 0;
      t2x_snap_q   <= 0;
      t2y_snap_q   <= 0;
      dir1_snap_q  <= DIR_UP;
      dir2_snap_q  <= DIR_UP;
      calc_valid_q <= 1'b0;
      calc_act_q   <= ACT_KILL;
      calc_x_q     <= BUL_OFF_5;
      calc_y_q     <= BUL_OFF_5;
      calc_idx_q   <= 9'd0;
      calc_dir_q   <= DIR_UP;
      calc_base_q  <= 2'b00;
      hit1_q       <= 1'b0;
      hit2_q       <= 1'b0;
      base_hit_q   <= 2'b00;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      map_q        <= map_d;
      bul1_q       <= bul1_d;
      bul2_q       <= bul2_d;
      fire1_snap_q <= fire1_snap_d;
      fire2_snap_q <= fire2_snap_d;
      t1x_snap_q   <= t1x_snap_d;
      t1y_snap_q   <= t1y_snap_d;
      t2x_snap_q   <= t2x_snap_d;
      t2y_snap_q   <= t2y_snap_d;
      dir1_snap_q  <= dir1_snap_d;
      dir2_snap_q  <= dir2_snap_d;
      calc_valid_q <= calc_valid_d;
      calc_act_q   <= calc_act_d;
      calc_x_q     <= calc_x_d;
      calc_y_q     <= calc_y_d;
      calc_idx_q   <= calc_idx_d;
      calc_dir_q   <= calc_dir_d;
      calc_base_q  <= calc_base_d;
      hit1_q       <= hit1_d;
      hit2_q       <= hit2_d;
      base_hit_q   <= base_hit_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    BulOneX  = bul1_q.active ? int'(bul1_q.x) : BUL_OFF;
    BulOneY  = bul1_q.active ? int'(bul1_q.y) : BUL_OFF;
    BulTwoX  = bul2_q.active ? int'(bul2_q.x) : BUL_OFF;
    BulTwoY  = bul2_q.active ? int'(bul2_q.y) : BUL_OFF;
    hit1     = hit1_q;
    hit2     = hit2_q;
    base_hit = base_hit_q;
    overrun  = overrun_q;
    busy     = (state_q != ST_IDLE);
    for (int i = 0; i < MAP_SIZE; i++) begin
      map[i] = int'(map_q[i]);
    end
  end

endmodule

// File: tb/tb_bullet_map_engine.sv
// Self-checking bench for bullet_map_engine: directed scenarios with
// literal expectations, then randomized frames compared every cycle
// against a frame-level behavioural model.
module tb_bullet_map_engine;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       fire1 = 1'b0, fire2 = 1'b0;
  int         TankOneX = 0, TankOneY = 0, TankTwoX = 0, TankTwoY = 0;
  logic [1:0] dir1 = 2'd0, dir2 = 2'd0;
  int         BulOneX, BulOneY, BulTwoX, BulTwoY;
  int         dut_map [300];
  logic       hit1, hit2, busy, overrun;
  logic [1:0] base_hit;

  bullet_map_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .fire1(fire1), .fire2(fire2),
    .TankOneX(TankOneX), .TankOneY(TankOneY),
    .TankTwoX(TankTwoX), .TankTwoY(TankTwoY),
    .dir1(dir1), .dir2(dir2),
    .BulOneX(BulOneX), .BulOneY(BulOneY), .BulTwoX(BulTwoX), .BulTwoY(BulTwoY),
    .map(dut_map), .hit1(hit1), .hit2(hit2), .base_hit(base_hit),
    .busy(busy), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  typedef struct {bit act; int x; int y; int d;} mbul_t;
  typedef struct {mbul_t b; int wr; int h1; int h2; int base;} rec_t;

  int    n_vec = 0, n_miss = 0;
  bit    checking = 0;
  int    vmap [300], fmap [300];
  mbul_t vb [2], fb [2];
  rec_t  rec [2];
  bit    pend = 0;
  int    ecount = 0, fstart = 0;
  int    exp_h1 = 0, exp_h2 = 0, exp_base = 0, exp_busy = 0, exp_ovr = 0;

  function automatic int start_tile(int x, int y);
    if (x == 10 && y == 0) return 4;
    if (x == 10 && y == 14) return 3;
    if (x >= 9 && x <= 11 && (y <= 1 || y >= 13)) return 2;
    if (x == 5 && y == 2) return 2;
    if ((y == 4 || y == 10) && x >= 8 && x <= 11) return 2;
    if (y == 7 && ((x >= 3 && x <= 6) || (x >= 13 && x <= 16))) return 1;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 300; i++) begin
      vmap[i] = start_tile(i % 20, i / 20);
      fmap[i] = vmap[i];
    end
    for (int k = 0; k < 2; k++) begin
      vb[k] = '{0, 31, 31, 0};
      fb[k] = vb[k];
    end
    pend = 0; exp_h1 = 0; exp_h2 = 0; exp_base = 0; exp_busy = 0; exp_ovr = 0;
  endtask

  // One bullet's whole frame step, from the game rules, on the future map.
  task automatic resolve(input int k);
    int ox, oy, sx, sy, d, tx, ty, code;
    rec_t r;
    r.wr = -1; r.h1 = 0; r.h2 = 0; r.base = 0; r.b = fb[k];
    ox = (k == 0) ? TankTwoX : TankOneX;
    oy = (k == 0) ? TankTwoY : TankOneY;
    if (fb[k].act) begin
      sx = fb[k].x; sy = fb[k].y; d = fb[k].d;
    end else if ((k == 0 ? fire1 : fire2) == 1'b1) begin
      sx = (k == 0) ? TankOneX : TankTwoX;
      sy = (k == 0) ? TankOneY : TankTwoY;
      d  = (k == 0) ? int'(dir1) : int'(dir2);
    end else begin
      rec[k] = r;
      return;
    end
    tx = sx + ((d == 1) ? 1 : (d == 3) ? -1 : 0);
    ty = sy + ((d == 2) ? 1 : (d == 0) ? -1 : 0);
    r.b = '{0, 31, 31, d};
    if (tx < 0 || tx > 19 || ty < 0 || ty > 14) begin
      r.wr = -1;
    end else if (tx == ox && ty == oy) begin
      if (k == 0) r.h2 = 1; else r.h1 = 1;
    end else begin
      code = fmap[ty*20 + tx];
      if (code == 0) r.b = '{1, tx, ty, d};
      if (code >= 2 && code <= 4) r.wr = ty*20 + tx;
      if (code == 3) r.base = 1;
      if (code == 4) r.base = 2;
    end
    if (r.wr >= 0) fmap[r.wr] = 0;
    fb[k] = r.b;
    rec[k] = r;
  endtask

  task automatic apply_rec(input int k);
    vb[k] = rec[k].b;
    if (rec[k].wr >= 0) vmap[rec[k].wr] = 0;
    exp_h1 = rec[k].h1; exp_h2 = rec[k].h2; exp_base = rec[k].base;
  endtask

  // Called right after each rising edge: what the outputs must show now.
  task automatic model_edge();
    bit in_frame;
    if (!Reset_n) return;
    ecount++;
    exp_h1 = 0; exp_h2 = 0; exp_base = 0; exp_ovr = 0;
    in_frame = pend && (ecount >= fstart + 1) && (ecount <= fstart + 4);
    if (pend && ecount == fstart + 2) apply_rec(0);
    if (pend && ecount == fstart + 4) begin
      apply_rec(1);
      pend = 0;
    end
    if (frame_tick) begin
      if (in_frame) exp_ovr = 1;
      else begin
        fstart = ecount;
        pend = 1;
        resolve(0);
        resolve(1);
      end
    end
    exp_busy = pend;
  endtask

  task automatic applyStimulus(input bit tick);
    frame_tick = tick;
    @(posedge Clk);
    model_edge();
    #1 frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    model_reset();
    applyStimulus(0);
    applyStimulus(0);
    Reset_n = 1'b1;
  endtask

  task automatic run_frame();
    applyStimulus(1);
    repeat (4) applyStimulus(0);
  endtask

  task automatic to_t2();
    applyStimulus(1);
    applyStimulus(0);
    applyStimulus(0);
    @(negedge Clk);
    #1;
  endtask

  task automatic set_tanks(input int ax, input int ay, input int bx, input int by);
    TankOneX = ax; TankOneY = ay; TankTwoX = bx; TankTwoY = by;
  endtask

  always @(negedge Clk) begin
    if (checking) begin
      int bad;
      bad = 0;
      checkOutput("busy", int'(busy), exp_busy);
      checkOutput("overrun", int'(overrun), exp_ovr);
      checkOutput("hit1", int'(hit1), exp_h1);
      checkOutput("hit2", int'(hit2), exp_h2);
      checkOutput("base_hit", int'(base_hit), exp_base);
      checkOutput("BulOneX", BulOneX, vb[0].act ? vb[0].x : 31);
      checkOutput("BulOneY", BulOneY, vb[0].act ? vb[0].y : 31);
      checkOutput("BulTwoX", BulTwoX, vb[1].act ? vb[1].x : 31);
      checkOutput("BulTwoY", BulTwoY, vb[1].act ? vb[1].y : 31);
      for (int i = 299; i >= 0; i--) if (dut_map[i] !== vmap[i]) bad = i;
      checkOutput($sformatf("map[%0d]", bad), dut_map[bad], vmap[bad]);
    end
  end

  initial begin
    model_reset();
    checking = 1;
    applyStimulus(0);
    applyStimulus(0);
    Reset_n = 1'b1;
    @(negedge Clk); #1;
    checkOutput("lit reset busy", int'(busy), 0);
    checkOutput("lit reset BulOneX", BulOneX, 31);
    checkOutput("lit reset BulTwoY", BulTwoY, 31);
    checkOutput("lit map[10] base2", dut_map[10], 4);
    checkOutput("lit map[290] base1", dut_map[290], 3);
    checkOutput("lit map[45] brick", dut_map[45], 2);
    checkOutput("lit map[143] steel", dut_map[143], 1);

    // Spawn then step right.
    set_tanks(5, 5, 15, 12); dir1 = 2'd1; fire1 = 1; fire2 = 0;
    to_t2();
    checkOutput("lit spawn BulOneX", BulOneX, 6);
    checkOutput("lit spawn BulOneY", BulOneY, 5);
    applyStimulus(0); applyStimulus(0); applyStimulus(0);
    fire1 = 0;
    run_frame();
    checkOutput("lit move BulOneX", BulOneX, 7);

    // Brick below tank one.
    do_reset();
    set_tanks(8, 3, 15, 12); dir1 = 2'd2; fire1 = 1;
    to_t2();
    checkOutput("lit brick map[88]", dut_map[88], 0);
    checkOutput("lit brick map[89]", dut_map[89], 2);
    checkOutput("lit brick BulOneX", BulOneX, 31);
    applyStimulus(0); applyStimulus(0); applyStimulus(0);

    // Off the right edge, then into steel.
    set_tanks(19, 3, 15, 12); dir1 = 2'd1;
    run_frame();
    checkOutput("lit edge BulOneX", BulOneX, 31);
    set_tanks(3, 6, 15, 12); dir1 = 2'd2;
    run_frame();
    checkOutput("lit steel map[143]", dut_map[143], 1);
    checkOutput("lit steel BulOneY", BulOneY, 31);

    // Tank two struck, pulse lasts one cycle.
    do_reset();
    set_tanks(1, 1, 2, 1); dir1 = 2'd1; fire1 = 1;
    to_t2();
    checkOutput("lit hit2 pulse", int'(hit2), 1);
    checkOutput("lit hit BulOneX", BulOneX, 31);
    applyStimulus(0);
    @(negedge Clk); #1;
    checkOutput("lit hit2 low", int'(hit2), 0);
    applyStimulus(0); applyStimulus(0);

    // Bullet passes over its own tank's tile.
    do_reset();
    set_tanks(1, 1, 15, 12); dir1 = 2'd1; fire1 = 1;
    run_frame();
    set_tanks(3, 1, 15, 12); fire1 = 0;
    to_t2();
    checkOutput("lit own tank hit1", int'(hit1), 0);
    checkOutput("lit own tank BulOneX", BulOneX, 3);
    applyStimulus(0); applyStimulus(0); applyStimulus(0);

    // Both bullets at brick 45, plus a tick while busy.
    do_reset();
    set_tanks(4, 2, 5, 3); dir1 = 2'd1; dir2 = 2'd0; fire1 = 1; fire2 = 1;
    applyStimulus(1); applyStimulus(0); applyStimulus(1);
    @(negedge Clk); #1;
    checkOutput("lit overrun", int'(overrun), 1);
    checkOutput("lit same map[45]", dut_map[45], 0);
    checkOutput("lit same BulOneX", BulOneX, 31);
    applyStimulus(0);
    @(negedge Clk); #1;
    checkOutput("lit overrun low", int'(overrun), 0);
    applyStimulus(0);
    @(negedge Clk); #1;
    checkOutput("lit same BulTwoX", BulTwoX, 5);
    checkOutput("lit same BulTwoY", BulTwoY, 2);
    applyStimulus(0);

    // Reset mid-frame.
    fire1 = 1; fire2 = 1;
    applyStimulus(1); applyStimulus(0);
    do_reset();
    @(negedge Clk); #1;
    checkOutput("lit midreset busy", int'(busy), 0);
    checkOutput("lit midreset BulTwoX", BulTwoX, 31);
    checkOutput("lit midreset map[45]", dut_map[45], 2);

    // Randomized frames.
    for (int f = 0; f < 300; f++) begin
      set_tanks($urandom_range(0, 19), $urandom_range(0, 14),
                $urandom_range(0, 19), $urandom_range(0, 14));
      dir1  = 2'($urandom_range(0, 3));
      dir2  = 2'($urandom_range(0, 3));
      fire1 = ($urandom_range(0, 99) < 40);
      fire2 = ($urandom_range(0, 99) < 40);
      applyStimulus(1);
      repeat ($urandom_range(2, 7)) applyStimulus(0);
      if ($urandom_range(0, 59) == 0) do_reset();
    end
    repeat (6) applyStimulus(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
